// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front-end for the shared combinational alu: registers the
// winning operands onto the ALU inputs, captures the result a cycle later, returns it tagged.
module alu_req_arbiter #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   any_valid;

    // Contention goes to whichever port did not win last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign any_valid  = req0_valid || req1_valid;
    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_a      <= grant ? req1_a   : req0_a;
                        alu_b      <= grant ? req1_b   : req0_b;
                        alu_sel    <= grant ? req1_sel : req0_sel;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_out;
                    rsp_carry  <= alu_carry;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Sequencing front-end for the shared combinational `alu` datapath (operands `A`, `B`, 4-bit `ALU_Sel`, result `ALU_Out`, `CarryOut`). Two requesters issue operations over valid/ready handshakes. The block arbitrates round-robin, registers the winning operands onto the ALU inputs, and captures the result one cycle later. It returns the result on a single response channel tagged with the requester id. Only one operation is in flight at a time.

## Interface
- `WIDTH`, default 8: operand and result width; must match the `alu` instance.
- `SEL_W`, default 4: opcode width; must match `ALU_Sel`.

Clock and reset:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.

Requester 0:
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_a`, `req0_b`  in  WIDTH  operands.
- `req0_sel`  in  SEL_W  ALU opcode.

Requester 1:
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sel`: same as requester 0.

ALU side:
- `alu_a`, `alu_b`  out  WIDTH  registered operands to `alu.A` / `alu.B`.
- `alu_sel`  out  SEL_W  registered opcode to `alu.ALU_Sel`.
- `alu_out`  in  WIDTH  from `alu.ALU_Out`.
- `alu_carry`  in  1  from `alu.CarryOut`.

Response channel:
- `rsp_valid`  out  1  response held valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  index of the requester that issued the operation.
- `rsp_result`  out  WIDTH  captured `alu_out`.
- `rsp_carry`  out  1  captured `alu_carry`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset value is IDLE.
- **IDLE**
  - Grant rule:
    - Only req0 valid → grant 0.
    - Only req1 valid → grant 1.
    - Both valid → grant the index not equal to `last_grant`.
  - `reqN_ready` = (state==IDLE) && granted N && `reqN_valid`. It is combinational and never high for both ports.
  - On fire (`valid && ready`):
    - Latch the granted `a`, `b`, `sel` into `alu_a`, `alu_b`, `alu_sel`.
    - Set `rsp_id` and `last_grant` to the grant.
    - Go to EXEC.
  - With no valid requester, stay in IDLE.
- **EXEC**, exactly one cycle:
  - Capture `alu_out` → `rsp_result` and `alu_carry` → `rsp_carry`.
  - Set `rsp_valid` = 1 and go to RESP.
- **RESP**
  - Hold `rsp_*` stable while `rsp_valid && !rsp_ready`.
  - On `rsp_ready`, clear `rsp_valid` and go to IDLE.
  - Both `reqN_ready` are low in RESP: no overlap, no skid.
- `alu_a`, `alu_b`, `alu_sel` hold their last values outside of accept. The ALU input therefore changes only on an accept edge.
- Requesters must hold their payload stable while valid and not ready. The block does not check this.
- The block performs no arithmetic. Width and opcode semantics belong entirely to `alu`. Result and carry are passed through unmodified.

## Timing
- Reset (async, `rst_n`=0), effective immediately:
  - State IDLE; `last_grant`=1, so req0 wins the first contention.
  - `alu_a`=`alu_b`=0, `alu_sel`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_carry`=0, `busy`=0.
  - `req0_ready` and `req1_ready` follow the IDLE rule, so they can be high while in reset.
- Cycle sequence for one operation:
  - Edge k: accept.
  - Edge k+1: capture; `rsp_valid` is high after edge k+1.
  - Earliest response handshake at edge k+2.
  - Next accept at edge k+3 at the earliest.
  - Peak throughput is one operation per 3 cycles.
- The ALU has a full cycle (edge k → k+1) to settle. It is combinational and must meet one clock period.
- Simultaneous valid on both ports alternates grants. A continuously valid pair yields the id sequence 0,1,0,1…
- A requester that drops valid before grant loses no state. `last_grant` updates only on fire.
- Reset asserted mid-operation (EXEC or RESP) aborts it:
  - No response is emitted.
  - The in-flight requester is not re-served.
- `rsp_ready` high in IDLE or EXEC has no effect.

## Test plan
- Reset, then req0 add (`sel`=0000, A=8'hFF, B=8'h01), `rsp_ready`=1 → `req0_ready` high 1 cycle; `rsp_valid` one cycle later with `rsp_id`=0, `rsp_result`=8'h00, `rsp_carry`=1; `busy` high 2 cycles.
- Both valid continuously: req0 (`sel`=1110, A=5, B=5), req1 (`sel`=0001, A=9, B=3) → responses alternate id 0 (result 1), id 1 (result 6), id 0, id 1, one every 3 cycles.
- Response back-pressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_*` stable all 5 cycles, both `reqN_ready` low; response and return to IDLE on the first `rsp_ready`=1 cycle.
- Only req1 valid after reset (A=8'h10, B=8'h20, `sel`=0000) → granted despite `last_grant` reset value; `rsp_id`=1, result 8'h30, carry 0.
- Assert `rst_n`=0 while in RESP with `rsp_ready`=0 → `rsp_valid`, `busy`, `alu_*` go to 0 asynchronously; after release, state is IDLE and no stale response appears.
- Req0 changes A from 3 to 7 while held in RESP, `sel`=0000, B=1 → the outstanding response is unchanged; the next accepted op returns 8'h08.
